// File: rtl/baud_gen.sv
`timescale 1ns/1ps
// baud_gen: UART baud-rate tick generator with an oversample (rx) tick and a bit-rate (tx) tick.
//   Ports: i_clk, i_reset (sync, active high), i_en, i_resync (phase restart),
//          i_div_wr/i_div/i_frac (divisor write), o_rx_tick, o_tx_tick, o_div_pending.
//   Optional macro BAUD_GEN_FRAC_EN enables the fractional divisor accumulator;
//   without it i_frac is ignored and every rx period is D_active+1 cycles.
module baud_gen #(
    parameter int CNT_W       = 16,
    parameter int OSR         = 16,
    parameter int DEFAULT_DIV = 26,
    parameter int FRAC_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_resync,
    input  logic              i_div_wr,
    input  logic [CNT_W-1:0]  i_div,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_rx_tick,
    output logic              o_tx_tick,
    output logic              o_div_pending
);
    localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

    // one extra bit so a stretched period of D_active+2 cannot overflow
    logic [CNT_W:0]   cnt_q, cnt_d, lim;
    logic [OW-1:0]    osr_q, osr_d;
    logic [CNT_W-1:0] div_q, div_d, pdiv_q, pdiv_d;
    logic             pend_q, pend_d, rx_q, rx_d, tx_q, tx_d;
    logic             extra, wrap, osr_last, apply_now;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d, pfrac_q, pfrac_d, acc_q, acc_d;
    logic [FRAC_W:0]   acc_sum;
    logic              ext_q, ext_d;
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
    assign extra   = ext_q;
`else
    logic unused_frac;
    assign unused_frac = ^i_frac;
    assign extra       = 1'b0;
`endif

    assign lim       = {1'b0, div_q} + {{CNT_W{1'b0}}, extra};
    // >= rather than == so a divisor shrunk below the held count still wraps
    assign wrap      = i_en && (cnt_q >= lim);
    assign osr_last  = (osr_q == OW'(OSR - 1));
    // while stopped or resyncing there is no period in flight to protect
    assign apply_now = !i_en || i_resync;

    always_comb begin
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        osr_d  = osr_q;
        rx_d   = 1'b0;
        tx_d   = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
        frac_d  = frac_q;
        pfrac_d = pfrac_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
`endif
        if (pend_q && (wrap || apply_now)) begin
            div_d  = pdiv_q;
            pend_d = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_d = pfrac_q;
`endif
        end
        if (i_div_wr && apply_now) begin
            div_d  = i_div;
            pend_d = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_d = i_frac;
`endif
        end else if (i_div_wr) begin
            pdiv_d = i_div;
            pend_d = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
            pfrac_d = i_frac;
`endif
        end
        if (i_resync) begin
            cnt_d = '0;
            osr_d = '0;
`ifdef BAUD_GEN_FRAC_EN
            acc_d = '0;
            ext_d = 1'b0;
`endif
        end else if (wrap) begin
            cnt_d = '0;
            osr_d = osr_last ? '0 : OW'(osr_q + 1'b1);
            rx_d  = 1'b1;
            tx_d  = osr_last;
`ifdef BAUD_GEN_FRAC_EN
            acc_d = acc_sum[FRAC_W-1:0];
            ext_d = acc_sum[FRAC_W];
`endif
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            osr_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            pdiv_q <= '0;
            pend_q <= 1'b0;
            rx_q   <= 1'b0;
            tx_q   <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_q  <= '0;
            pfrac_q <= '0;
            acc_q   <= '0;
            ext_q   <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            osr_q  <= osr_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
`ifdef BAUD_GEN_FRAC_EN
            frac_q  <= frac_d;
            pfrac_q <= pfrac_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
`endif
        end
    end

    assign o_rx_tick     = rx_q;
    assign o_tx_tick     = tx_q;
    assign o_div_pending = pend_q;
endmodule

// File: tb/tb_baud_gen.sv
`timescale 1ns/1ps
// tb_baud_gen: scoreboard bench for baud_gen; expected tick cycles are queued, a monitor pops them.
module tb_baud_gen;
    logic clk = 1'b0;
    logic rst, en, resync, div_wr;
    logic [15:0] div;
    logic [3:0] frac;
    logic rx, tx, pend;
    logic rst2, en2, wr2;
    logic [15:0] div2;
    logic rx2, tx2, pend2;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {int c; bit t;} exp_t;
    exp_t q[$];

    baud_gen dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_resync(resync), .i_div_wr(div_wr),
        .i_div(div), .i_frac(frac), .o_rx_tick(rx), .o_tx_tick(tx), .o_div_pending(pend)
    );

    baud_gen #(.OSR(1)) dut2 (
        .i_clk(clk), .i_reset(rst2), .i_en(en2), .i_resync(1'b0), .i_div_wr(wr2),
        .i_div(div2), .i_frac(4'd0), .o_rx_tick(rx2), .o_tx_tick(tx2), .o_div_pending(pend2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void push(input int c, input bit t);
        exp_t e;
        e.c = c;
        e.t = t;
        q.push_back(e);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].c < cyc) begin
                exp_t m;
                m = q.pop_front();
                chk("rx_tick_missing", 0, m.c);
            end
            if (rx === 1'b1) begin
                if (q.size() == 0) chk("rx_tick_unexpected", cyc, -1);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rx_tick_cycle", cyc, e.c);
                    chk("tx_tick_with_rx", int'(tx), int'(e.t));
                end
            end else if (tx === 1'b1) chk("tx_without_rx", 1, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, t, u, v, w, x, y, n;
        rst = 1; en = 0; resync = 0; div_wr = 0; div = 0; frac = 0;
        rst2 = 1; en2 = 0; wr2 = 0; div2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_rx", int'(rx), 0);
        chk("reset_tx", int'(tx), 0);
        chk("reset_pending", int'(pend), 0);
        // defaults: rx every 27, tx on the 16th rx tick
        r = cyc;
        for (int k = 1; k <= 17; k++) push(r + 27 * k, k == 16);
        mon_en = 1;
        rst = 0; en = 1;
        // disable for 10 cycles at prescale count 12
        wait_until(r + 471); en = 0;
        wait_until(r + 481); en = 1;
        t = r + 496;
        push(t, 0);
        // write D=3 mid-period
        wait_until(t + 5);
        push(t + 27, 0);
        for (int m = 1; m <= 13; m++) push(t + 27 + 4 * m, m == 13);
        div_wr = 1; div = 3;
        wait_until(t + 6); div_wr = 0;
        chk("pending_after_write", int'(pend), 1);
        wait_until(t + 26); chk("pending_before_wrap", int'(pend), 1);
        wait_until(t + 27); chk("pending_cleared_at_wrap", int'(pend), 0);
        // resync coinciding with a wrap restarts rx and tx phase
        u = t + 79;
        push(u + 4, 0); push(u + 8, 0);
        for (int j = 1; j <= 16; j++) push(u + 16 + 4 * (j - 1), j == 16);
        wait_until(u + 11); resync = 1;
        wait_until(u + 12); resync = 0;
        chk("no_tick_after_resync", int'(rx), 0);
        // write while disabled applies immediately
        v = u + 76;
        push(v + 8, 0); push(v + 14, 0);
        wait_until(v + 2); en = 0; div_wr = 1; div = 5;
        wait_until(v + 3); div_wr = 0;
        chk("pending_write_while_disabled", int'(pend), 0);
        wait_until(v + 4); en = 1;
        // back-to-back writes: only the last one applies
        w = v + 14;
        push(w + 6, 0); push(w + 9, 0); push(w + 12, 0);
        wait_until(w + 1); div_wr = 1; div = 9;
        wait_until(w + 2); div = 2;
        wait_until(w + 3); div_wr = 0;
        chk("pending_double_write", int'(pend), 1);
        wait_until(w + 6); chk("pending_cleared_double", int'(pend), 0);
        // write + resync together, D=26 F=8
        x = w + 12;
        push(x + 29, 0); push(x + 56, 0);
`ifdef BAUD_GEN_FRAC_EN
        push(x + 84, 0); push(x + 111, 0);
        y = x + 112;
`else
        push(x + 83, 0); push(x + 110, 0);
        y = x + 111;
`endif
        wait_until(x + 1); resync = 1; div_wr = 1; div = 26; frac = 8;
        wait_until(x + 2); resync = 0; div_wr = 0;
        chk("pending_write_with_resync", int'(pend), 0);
        chk("no_tick_write_resync", int'(rx), 0);
        // reset mid-write discards pending divisor
        wait_until(y); div_wr = 1; div = 4;
        wait_until(y + 1); div_wr = 0;
        chk("pending_before_reset", int'(pend), 1);
        rst = 1;
        wait_until(y + 2);
        chk("midrun_reset_rx", int'(rx), 0);
        chk("midrun_reset_tx", int'(tx), 0);
        chk("midrun_reset_pending", int'(pend), 0);
        push(y + 29, 0);
        rst = 0;
        wait_until(y + 31);
        chk("scoreboard_empty", q.size(), 0);
        mon_en = 0;
        // OSR=1, D=0: both ticks every cycle, then reset restores D=26
        n = cyc;
        rst2 = 0; wr2 = 1; div2 = 0;
        wait_until(n + 1); wr2 = 0; en2 = 1;
        for (int i = 2; i <= 5; i++) begin
            wait_until(n + i);
            chk("d0_rx_every_cycle", int'(rx2), 1);
            chk("d0_tx_every_cycle", int'(tx2), 1);
        end
        rst2 = 1;
        wait_until(n + 6);
        chk("d0_reset_rx", int'(rx2), 0);
        chk("d0_reset_tx", int'(tx2), 0);
        rst2 = 0;
        wait_until(n + 32); chk("d0_reset_div_no_early_tick", int'(rx2), 0);
        wait_until(n + 33);
        chk("d0_reset_div_rx", int'(rx2), 1);
        chk("d0_reset_div_tx", int'(tx2), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the divisor and prescale counter.
REQ-002 Parameter OSR, default 16: oversample ratio, meaning rx ticks per tx tick; legal range 1..256.
REQ-003 Parameter DEFAULT_DIV, default 26: divisor loaded at reset; rx tick period is DEFAULT_DIV+1 cycles.
REQ-004 Parameter FRAC_W, default 4: width of the fractional divisor field.
REQ-005 i_clk  input  1: single system clock; all logic on its rising edge.
REQ-006 i_reset  input  1: synchronous, active-high reset.
REQ-007 i_en  input  1: generator enable.
REQ-008 i_resync  input  1: single-cycle pulse that restarts tick phase (RX start-bit alignment).
REQ-009 i_div_wr  input  1: divisor write strobe.
REQ-010 i_div  input  CNT_W: new integer divisor D; period is D+1 cycles.
REQ-011 i_frac  input  FRAC_W: new fractional divisor F, captured with i_div_wr.
REQ-012 o_rx_tick  output  1: registered one-cycle oversample pulse.
REQ-013 o_tx_tick  output  1: registered one-cycle bit-rate pulse.
REQ-014 o_div_pending  output  1: high while a written divisor awaits application.

Function
REQ-015 Prescale counter counts 0..D_active; on the cycle it equals D_active it wraps to 0 and o_rx_tick is 1 the following cycle; otherwise o_rx_tick is 0.
REQ-016 With i_en=1 from the first edge after reset, the first o_rx_tick is high on cycle D+1 (edge 1 = first enabled edge); thereafter every D+1 cycles.
REQ-017 D=0 is legal: o_rx_tick is high on every cycle while enabled.
REQ-018 OSR counter advances on each rx wrap and counts 0..OSR-1; o_tx_tick is high in the same cycle as the rx tick produced by wrap OSR-1->0.
REQ-019 OSR=1: o_tx_tick identical to o_rx_tick.
REQ-020 i_en=0: both counters hold their values and both ticks are 0; counting resumes from the held values when i_en returns to 1.
REQ-021 i_resync=1: both counters and the fractional accumulator clear to 0 next cycle; no tick is issued in the cycle following resync, even if a wrap coincided; works regardless of i_en.
REQ-022 i_div_wr=1: i_div/i_frac are captured into a pending register and o_div_pending=1 next cycle.
REQ-023 A pending divisor becomes D_active at the next rx wrap (glitch-free; the current period completes with the old value); o_div_pending clears in that cycle.
REQ-024 If i_en=0 or i_resync=1 coincides with or follows a write, the pending value applies immediately on the next edge.
REQ-025 A second write before application overwrites the pending value; only the last is applied.
REQ-026 i_div_wr and i_resync in the same cycle: the new divisor is applied at once and counters clear.

Reset
REQ-027 On i_clk edge with i_reset=1: counters=0, accumulator=0, D_active=DEFAULT_DIV, F_active=0, o_rx_tick=0, o_tx_tick=0, o_div_pending=0.
REQ-028 Reset overrides all other inputs, including mid-period and mid-write; the pending write is discarded.

Configuration
REQ-029 Macro BAUD_GEN_FRAC_EN: when defined, at each rx wrap accumulator <= (accumulator + F_active) mod 2^FRAC_W; on carry-out the next rx period lasts D_active+2 cycles.
REQ-030 Without BAUD_GEN_FRAC_EN: i_frac is ignored, no accumulator exists, and the period is always D_active+1.

Verification
REQ-031 Reset, i_en=1, defaults -> o_rx_tick first at cycle 27, then every 27 cycles; o_tx_tick every 432 cycles, coincident with the 16th rx tick.
REQ-032 Write D=3 mid-period with D_active=26 -> current 27-cycle period completes, o_div_pending is 1 until that wrap, then ticks every 4 cycles.
REQ-033 i_en low for 10 cycles at prescale count 12 -> no ticks; the next tick arrives 15 cycles after re-enable.
REQ-034 i_resync on the same cycle as a wrap -> no tick next cycle; next rx tick D+1 cycles later; tx phase restarted (tx tick after 16 more rx ticks).
REQ-035 With BAUD_GEN_FRAC_EN, D=26, F=8, FRAC_W=4 -> rx periods alternate 27, 28 cycles (mean 27.5); without the macro all periods are 27.
REQ-036 D=0, OSR=1 -> o_rx_tick and o_tx_tick high every cycle; assert i_reset mid-run -> both are 0 next cycle and D_active=26.
